ahci_dma_prd_sched: RTL and testbench

//  Sequences one PRD entry at a time into the hclk-side DMA read path: arms the

---
 rtl/ahci_dma_pkg.sv | 9 +
 rtl/ahci_dma_burst_len.sv | 22 ++
 rtl/ahci_dma_prd_sched.sv | 132 +++++++++++++
 tb/tb_ahci_dma_prd_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahci_dma_pkg.sv
// ahci_dma_pkg: shared states, burst/page limits and PRD qword-count helper for the AHCI DMA paths
package ahci_dma_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_R, S_WAIT_DONE} state_t;
  localparam int QW_PER_BURST = 16;
  localparam int PAGE_QW = 512;
  function automatic logic [31:0] qw_count(input logic [1:0] woffs, input logic [31:0] wcnt);
    return ((wcnt + {30'd0, woffs}) >> 2) + 32'd1;
  endfunction
endpackage

// File: rtl/ahci_dma_burst_len.sv
// ahci_dma_burst_len: burst size n = min(16, qrem, page room, credit)
module ahci_dma_burst_len
  import ahci_dma_pkg::*;
#(
  parameter int RW = 20,
  parameter int CW = 5
) (
  input  logic [RW-1:0] qrem,
  input  logic [9:0]    room,
  input  logic [CW-1:0] credit,
  output logic [4:0]    n
);
  localparam logic [4:0] B = 5'(QW_PER_BURST);
  logic [4:0] a, b, c, m;
  always_comb begin
    a = (qrem >= RW'(QW_PER_BURST)) ? B : qrem[4:0];
    b = (room >= 10'(QW_PER_BURST)) ? B : room[4:0];
    c = (credit >= CW'(QW_PER_BURST)) ? B : credit[4:0];
    m = (a < b) ? a : b;
    n = (m < c) ? m : c;
  end
endmodule

// File: rtl/ahci_dma_prd_sched.sv
// ahci_dma_prd_sched: arms the read FIFO per PRD and splits it into credit-throttled, page-safe AXI AR bursts (stats ports with AHCI_DMA_PRD_STATS_EN)
module ahci_dma_prd_sched
  import ahci_dma_pkg::*;
#(
  parameter int WCNT_BITS = 21,
  parameter int FIFO_QW   = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                 hclk,
  input  logic                 hrst_n,
  input  logic [31:0]          prd_addr,
  input  logic [WCNT_BITS-1:0] prd_wcnt,
  input  logic                 prd_last,
  input  logic                 prd_valid,
  output logic                 prd_ready,
  input  logic                 abort,
  output logic                 fifo_start,
  output logic [WCNT_BITS-1:0] fifo_wcnt,
  output logic [1:0]           fifo_woffs,
  output logic                 fifo_flush,
  input  logic                 fifo_din_re,
  input  logic                 fifo_done,
  output logic [31:0]          ar_addr,
  output logic [3:0]           ar_len,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic                 r_last_hs,
  output logic                 busy,
  output logic                 prd_done
`ifdef AHCI_DMA_PRD_STATS_EN
  ,
  output logic [15:0]          stat_bursts,
  output logic [31:0]          stat_qwords
`endif
);
  localparam int RW = WCNT_BITS - 1;
  localparam int CW = $clog2(FIFO_QW) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  state_t state, state_n;
  logic [31:1] addr_r;
  logic flush_r, ab_r, ab, hs, offer;
  logic [28:0] qaddr;
  logic [RW-1:0] qrem;
  logic [CW-1:0] credit;
  logic [OW-1:0] outst;
  logic [4:0] n, n_r;
  logic unused_addr0;
  assign unused_addr0 = prd_addr[0];
  ahci_dma_burst_len #(.RW(RW), .CW(CW)) u_len (
    .qrem(qrem),
    .room(10'(PAGE_QW) - {1'b0, qaddr[8:0]}),
    .credit(credit),
    .n(n)
  );
  assign ab = abort | ab_r;
  assign hs = ar_valid & ar_ready;
  // offer is registered so ar_len stays frozen while credits trickle in during a stalled offer
  assign offer = state == S_ISSUE && !ar_valid && !ab && n != 5'd0 && outst < OW'(MAX_OUTST);
  assign prd_ready = state == S_IDLE;
  assign fifo_start = state == S_LOAD;
  assign busy = state != S_IDLE;
  assign fifo_woffs = addr_r[2:1];
  assign fifo_flush = flush_r & busy;
  assign ar_addr = {qaddr, 3'b000};
  assign prd_done = state == S_WAIT_DONE && fifo_done && !ab;
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = prd_valid ? S_LOAD : S_IDLE;
      S_LOAD:      state_n = ab ? S_WAIT_R : S_ISSUE;
      S_ISSUE:     state_n = hs ? ((qrem == RW'(n_r) || ab) ? S_WAIT_R : S_ISSUE)
                                : ((!ar_valid && ab) ? S_WAIT_R : S_ISSUE);
      S_WAIT_R:    state_n = outst != '0 ? S_WAIT_R : (ab ? S_IDLE : S_WAIT_DONE);
      S_WAIT_DONE: state_n = (ab || fifo_done) ? S_IDLE : S_WAIT_DONE;
      default:     state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) begin
      addr_r    <= '0;
      fifo_wcnt <= '0;
      flush_r   <= 1'b0;
      ab_r      <= 1'b0;
      qaddr     <= '0;
      qrem      <= '0;
      credit    <= CW'(FIFO_QW);
      outst     <= '0;
      ar_valid  <= 1'b0;
      ar_len    <= '0;
      n_r       <= '0;
    end else begin
      assert (credit <= CW'(FIFO_QW));
      credit <= credit - (hs ? CW'(n_r) : CW'(0)) + CW'(fifo_din_re);
      outst  <= outst + OW'(hs) - OW'(r_last_hs);
      ab_r   <= state != S_IDLE && ab;
      if (prd_valid && prd_ready) begin
        addr_r    <= prd_addr[31:1];
        fifo_wcnt <= prd_wcnt;
        flush_r   <= prd_last;
      end
      if (state == S_LOAD) begin
        qaddr <= addr_r[31:3];
        qrem  <= RW'(qw_count(addr_r[2:1], 32'(fifo_wcnt)));
      end
      if (offer) begin
        ar_valid <= 1'b1;
        ar_len   <= 4'(n - 5'd1);
        n_r      <= n;
      end
      if (hs) begin
        ar_valid <= 1'b0;
        qaddr    <= qaddr + 29'(n_r);
        qrem     <= qrem - RW'(n_r);
      end
    end
`ifdef AHCI_DMA_PRD_STATS_EN
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) begin
      stat_bursts <= '0;
      stat_qwords <= '0;
    end else if (state == S_LOAD) begin
      stat_bursts <= '0;
      stat_qwords <= '0;
    end else if (hs) begin
      stat_bursts <= stat_bursts + 16'd1;
      stat_qwords <= stat_qwords + 32'(n_r);
    end
`endif
endmodule

// File: tb/tb_ahci_dma_prd_sched.sv
// tb_ahci_dma_prd_sched: scoreboard bench for the PRD burst scheduler
module tb_ahci_dma_prd_sched;
  localparam int BIG = 1000000;
  logic hclk = 1'b0, hrst_n = 1'b0;
  logic [31:0] prd_addr = '0;
  logic [20:0] prd_wcnt = '0;
  logic prd_last = 1'b0, prd_valid = 1'b0, abort = 1'b0;
  logic fifo_din_re = 1'b0, fifo_done = 1'b0, ar_ready = 1'b0, r_last_hs = 1'b0;
  logic prd_ready, fifo_start, fifo_flush, ar_valid, busy, prd_done;
  logic [20:0] fifo_wcnt;
  logic [1:0] fifo_woffs;
  logic [31:0] ar_addr;
  logic [3:0] ar_len;
  typedef struct {logic [31:0] addr; logic [3:0] len;} ar_t;
  ar_t exp_q[$];
  int total, bad, hs_total, qw_total, r_done, din_done, done_cnt;
  int r_allow = BIG, din_allow = BIG;
  always #5 hclk = ~hclk;
  ahci_dma_prd_sched #(.WCNT_BITS(21), .FIFO_QW(16), .MAX_OUTST(2)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .prd_addr(prd_addr), .prd_wcnt(prd_wcnt),
    .prd_last(prd_last), .prd_valid(prd_valid), .prd_ready(prd_ready), .abort(abort),
    .fifo_start(fifo_start), .fifo_wcnt(fifo_wcnt), .fifo_woffs(fifo_woffs),
    .fifo_flush(fifo_flush), .fifo_din_re(fifo_din_re), .fifo_done(fifo_done),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_last_hs(r_last_hs), .busy(busy), .prd_done(prd_done)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  always @(negedge hclk) begin : monitor
    ar_t e;
    if (hrst_n) begin
      if (ar_valid && ar_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ar_unexpected: got addr %0h len %0d want no burst", ar_addr, ar_len);
        end else begin
          e = exp_q.pop_front();
          chk("ar_addr", 64'(ar_addr), 64'(e.addr));
          chk("ar_len", 64'(ar_len), 64'(e.len));
        end
        hs_total++;
        qw_total += int'(ar_len) + 1;
      end
      if (prd_done) done_cnt++;
    end
  end
  always @(posedge hclk) begin
    #1;
    r_last_hs = r_done < hs_total && r_done < r_allow;
    if (r_last_hs) r_done++;
    fifo_din_re = din_done < qw_total && din_done < din_allow;
    if (fifo_din_re) din_done++;
  end
  task automatic push(input logic [31:0] a, input logic [3:0] l);
    ar_t e;
    e.addr = a;
    e.len = l;
    exp_q.push_back(e);
  endtask
  task automatic wait_hs(input int tgt);
    int n = 0;
    while (hs_total < tgt && n < 300) begin
      @(negedge hclk);
      n++;
    end
    chk("hs_count", 64'(hs_total), 64'(tgt));
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!prd_ready && n < 300) begin
      @(negedge hclk);
      n++;
    end
    chk("prd_ready", 64'(prd_ready), 64'd1);
  endtask
  task automatic run_prd(input logic [31:0] a, input logic [20:0] w, input logic l);
    wait_ready();
    tick();
    prd_addr = a;
    prd_wcnt = w;
    prd_last = l;
    prd_valid = 1'b1;
    tick();
    prd_valid = 1'b0;
    @(negedge hclk);
    chk("fifo_start", 64'(fifo_start), 64'd1);
    chk("fifo_woffs", 64'(fifo_woffs), 64'(a[2:1]));
    chk("fifo_wcnt", 64'(fifo_wcnt), 64'(w));
    chk("fifo_flush", 64'(fifo_flush), 64'(l));
  endtask
  task automatic drain();
    int n = 0;
    while ((r_done < hs_total || din_done < qw_total) && n < 300) begin
      @(negedge hclk);
      n++;
    end
    chk("drain", 64'(r_done == hs_total && din_done == qw_total), 64'd1);
  endtask
  task automatic finish_prd(input logic l);
    int d0;
    drain();
    repeat (4) @(negedge hclk);
    d0 = done_cnt;
    chk("no_early_done", 64'(prd_done), 64'd0);
    chk("busy_wait_done", 64'(busy), 64'd1);
    chk("flush_held", 64'(fifo_flush), 64'(l));
    tick();
    fifo_done = 1'b1;
    @(negedge hclk);
    chk("prd_done", 64'(prd_done), 64'd1);
    tick();
    fifo_done = 1'b0;
    @(negedge hclk);
    chk("idle_ready", 64'(prd_ready), 64'd1);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask
  initial begin
    int h0, d0;
    logic [31:0] a;
    logic [3:0] l;
    ar_ready = 1'b1;
    repeat (2) @(negedge hclk);
    chk("rst_prd_ready", 64'(prd_ready), 64'd1);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_start", 64'(fifo_start), 64'd0);
    chk("rst_ar_addr", 64'(ar_addr), 64'd0);
    tick();
    hrst_n = 1'b1;
    // aligned 4 QW, woffs 1 2 QW, page crossing
    push(32'h1000, 4'd3);
    run_prd(32'h1000, 21'd15, 1'b0);
    wait_hs(1);
    finish_prd(1'b0);
    push(32'h1000, 4'd1);
    run_prd(32'h1002, 21'd3, 1'b1);
    wait_hs(2);
    finish_prd(1'b1);
    push(32'h0FF8, 4'd0);
    push(32'h1000, 4'd1);
    run_prd(32'h0FF8, 21'd11, 1'b0);
    wait_hs(4);
    finish_prd(1'b0);
    // ar_ready stall: offer must hold
    tick();
    ar_ready = 1'b0;
    push(32'h4000, 4'd15);
    run_prd(32'h4000, 21'd63, 1'b0);
    for (int i = 0; i < 50 && !ar_valid; i++) @(negedge hclk);
    a = ar_addr;
    l = ar_len;
    chk("stall_addr", 64'(a), 64'h4000);
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      chk("stall_stable", 64'({ar_valid, ar_len, ar_addr}), 64'({1'b1, l, a}));
    end
    tick();
    ar_ready = 1'b1;
    wait_hs(5);
    finish_prd(1'b0);
    // credit throttle, outstanding limit, then abort mid-PRD
    @(negedge hclk);
    r_allow = r_done;
    din_allow = din_done;
    h0 = hs_total;
    d0 = done_cnt;
    push(32'h2000, 4'd15);
    run_prd(32'h2000, 21'd255, 1'b0);
    wait_hs(h0 + 1);
    repeat (10) @(negedge hclk);
    chk("credit_stall", 64'(ar_valid), 64'd0);
    push(32'h2080, 4'd0);
    din_allow = din_done + 1;
    wait_hs(h0 + 2);
    repeat (3) @(negedge hclk);
    din_allow = din_done + 4;
    repeat (10) @(negedge hclk);
    chk("outst_stall", 64'(ar_valid), 64'd0);
    push(32'h2088, 4'd3);
    r_allow = r_done + 1;
    wait_hs(h0 + 3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge hclk);
    din_allow = BIG;
    repeat (20) @(negedge hclk);
    chk("abort_no_ar", 64'(ar_valid), 64'd0);
    chk("abort_drain_busy", 64'(busy), 64'd1);
    r_allow = BIG;
    wait_ready();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    drain();
    // abort during a stalled offer: burst still completes, nothing after it
    tick();
    ar_ready = 1'b0;
    h0 = hs_total;
    push(32'h3000, 4'd15);
    run_prd(32'h3000, 21'd191, 1'b1);
    for (int i = 0; i < 50 && !ar_valid; i++) @(negedge hclk);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) @(negedge hclk);
    chk("abort_hold_offer", 64'({ar_valid, ar_addr}), 64'({1'b1, 32'h3000}));
    tick();
    ar_ready = 1'b1;
    wait_hs(h0 + 1);
    repeat (15) @(negedge hclk);
    chk("abort2_no_ar", 64'(ar_valid), 64'd0);
    wait_ready();
    chk("abort2_no_done", 64'(done_cnt), 64'(d0));
    drain();
    // normal PRD after aborts
    push(32'h5000, 4'd0);
    run_prd(32'h5004, 21'd0, 1'b1);
    wait_hs(h0 + 2);
    finish_prd(1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
